cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Miss-handling controller for the direct-mapped, write-back cache (`direct_Cache`) and its backing word memory. It accepts one processor load/store at a time and issues compare accesses to the cache. On a miss it writes back a dirty victim line word-by-word, fills the line from memory, then replays the access. It sits between the processor port and the cache/memory pair and is the only block that drives the cache's `comp`/`write`/`valid_in` controls.

## Interface
- `TAG_W`, default 5: tag bits, `addr[12:8]`.
- `IDX_W`, default 6: line index bits, `addr[7:2]`.
- `OFF_W`, default 2: word offset bits, `addr[1:0]`. Line size is 2^OFF_W 16-bit words.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: processor request, sampled only in IDLE.
- `wr` in 1: 1 = store, 0 = load.
- `addr` in 13: word address.
- `wdata` in 16: store data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 16: load data, valid while `done` = 1.
- `c_en`, `c_comp`, `c_write`, `c_valid_in` out 1 each: cache controls.
- `c_addr` out 13: cache address.
- `c_tag_in` out 5: cache tag.
- `c_din` out 16: cache write data.
- `c_hit`, `c_dirty`, `c_valid` in 1 each: cache status.
- `c_tag_out` in 5: cache tag readback.
- `c_dout` in 16: cache read data.
- `m_req`, `m_we` out 1 each: memory request and write enable.
- `m_addr` out 13: memory address.
- `m_wdata` out 16: memory write data.
- `m_ack` in 1: memory completion.
- `m_rdata` in 16: memory read data, valid with `m_ack`.

## Operation
- Cache modes: compare-read (`comp`=1, `write`=0), compare-write (1,1: writes the word on hit and sets dirty), access-read (0,0), access-write (0,1: writes word and tag, sets valid, clears dirty).
- Cache outputs settle combinationally; the controller samples them on the edge ending the access cycle.
- IDLE: when `req`=1, latch `addr`, `wr` and `wdata` into a request register, then go to COMP. Processor inputs are ignored until `done`.
- COMP: compare access with `c_tag_in` = tag.
  - `c_hit`=1 and `c_valid`=1 → DONE.
  - Miss with `c_valid`=1 and `c_dirty`=1 → latch `c_tag_out` as the victim tag, clear word counter `wc`, go to WB.
  - Otherwise → clear `wc`, go to FILL.
- WB, per word:
  - Access-read cache at {victim tag, index, wc}.
  - Hold `m_req`=1, `m_we`=1, `m_addr` = {victim tag, index, wc}, `m_wdata` = captured `c_dout` until `m_ack`.
  - On `m_ack`, increment `wc`. After the last word → `wc`=0, FILL.
- FILL, per word:
  - Hold `m_req`=1, `m_we`=0, `m_addr` = {tag, index, wc} until `m_ack`; latch `m_rdata`.
  - Next cycle (FWR): access-write the cache at the same address with `c_valid_in`=1, then increment `wc`.
  - After the last word → COMP (replay). The replay must hit.
- DONE:
  - `done`=1 for one cycle; `rdata` = `c_dout` captured in COMP on loads, 0 on stores.
  - Store hits were already written by compare-write in COMP.
  - Return to IDLE.
- `wc` is OFF_W bits wide and wraps to 0 after the last word; the wrap is the exit condition.
- A miss with `c_valid`=0 never writes back, regardless of `c_dirty`.
- `m_ack` outside a pending request is ignored. `m_req` deasserts the cycle after `m_ack`.
- `c_en`=1 only in COMP, WB-read and FWR cycles.

## Timing
- Reset values: `busy`, `done`, `m_req`, `m_we`, `c_en`, `c_comp`, `c_write`, `c_valid_in` = 0; `rdata`, `m_addr`, `m_wdata`, `c_addr`, `c_din`, `c_tag_in` = 0; state IDLE; `wc` = 0.
- Reset asserted mid-operation: all outputs return to reset values immediately. Any memory request in flight is abandoned and no `done` is produced. A partially filled line may be left valid; software must not rely on its contents.
- Hit latency: `req` sampled at edge 0, COMP cycle 1, `done` high in cycle 2.
- Miss with memory ack latency L (cycles from `m_req` rise to `m_ack`, L ≥ 1):
  - Clean miss: `done` at cycle 2 + 4·(L+1) + 1.
  - Dirty miss: add 4·(L+1) for writeback.
- `req` held high through DONE is re-accepted in the IDLE cycle after DONE, never in the same cycle.

## Test plan
- Read hit: preload line idx 3 tag 0x05 valid clean; load addr 0x050D → `done` at cycle 2, `rdata` equals the preloaded word 1, no `m_req`.
- Clean read miss, L=2: load 0x0A10 to an invalid line → four reads at 0x0A10..0x0A13, four access-writes, then a replay hit; `done` at cycle 15; `rdata` = mem[0x0A10].
- Dirty miss: line idx 4 holds tag 0x02, dirty; load 0x1F12 → writes to mem 0x0210..0x0213 carry the old cache words, followed by a fill from 0x1F10..0x1F13; total 27 cycles at L=2.
- Store miss then load hit: store 0xBEEF at 0x0345 → allocate, `done`. Then load 0x0345 → `rdata`=0xBEEF in 2 cycles and the line reads dirty.
- Invalid-but-dirty line: `c_valid`=0, `c_dirty`=1 on miss → no `m_we` pulses, fill only.
- Reset mid-fill: drop `rst_n` after the second `m_ack` → all outputs 0 immediately, state IDLE. Release reset and issue a new request → normal 2-cycle hit or full miss sequence.

Source files
------------

// File: rtl/cache_ctrl.sv
// Miss-handling controller for a direct-mapped write-back cache: compare access,
// word-by-word victim writeback, line fill from memory, then replay of the access.
module cache_ctrl #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned OFF_W = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic                           wr,
  input  logic [TAG_W+IDX_W+OFF_W-1:0]   addr,
  input  logic [15:0]                    wdata,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    rdata,
  output logic                           c_en,
  output logic                           c_comp,
  output logic                           c_write,
  output logic                           c_valid_in,
  output logic [TAG_W+IDX_W+OFF_W-1:0]   c_addr,
  output logic [TAG_W-1:0]               c_tag_in,
  output logic [15:0]                    c_din,
  input  logic                           c_hit,
  input  logic                           c_dirty,
  input  logic                           c_valid,
  input  logic [TAG_W-1:0]               c_tag_out,
  input  logic [15:0]                    c_dout,
  output logic                           m_req,
  output logic                           m_we,
  output logic [TAG_W+IDX_W+OFF_W-1:0]   m_addr,
  output logic [15:0]                    m_wdata,
  input  logic                           m_ack,
  input  logic [15:0]                    m_rdata
);
  localparam int unsigned AW = TAG_W + IDX_W + OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_COMP, S_WB_RD, S_WB_MEM, S_FILL, S_FWR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic              rw_q, rw_d;
  logic [15:0]       rwd_q, rwd_d;
  logic [TAG_W-1:0]  victim_q, victim_d;
  logic [OFF_W-1:0]  wc_q, wc_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              c_en_q, c_en_d, c_comp_q, c_comp_d, c_write_q, c_write_d, c_valid_in_q, c_valid_in_d;
  logic [AW-1:0]     c_addr_q, c_addr_d;
  logic [TAG_W-1:0]  c_tag_in_q, c_tag_in_d;
  logic [15:0]       c_din_q, c_din_d;
  logic              m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [15:0]       m_wdata_q, m_wdata_d;

  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [OFF_W-1:0]  wc_inc;
  logic              wc_last;

  assign r_tag   = ra_q[AW-1 -: TAG_W];
  assign r_idx   = ra_q[OFF_W +: IDX_W];
  assign wc_inc  = wc_q + 1'b1;
  assign wc_last = (wc_q == '1);

  // Output registers are loaded with the values for the state being entered,
  // so every control is stable for the whole cycle it belongs to.
  always_comb begin
    state_d      = state_q;
    ra_d         = ra_q;
    rw_d         = rw_q;
    rwd_d        = rwd_q;
    victim_d     = victim_q;
    wc_d         = wc_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    c_en_d       = 1'b0;
    c_comp_d     = 1'b0;
    c_write_d    = 1'b0;
    c_valid_in_d = 1'b0;
    c_addr_d     = c_addr_q;
    c_tag_in_d   = c_tag_in_q;
    c_din_d      = c_din_q;
    m_req_d      = 1'b0;
    m_we_d       = 1'b0;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        ra_d       = addr;
        rw_d       = wr;
        rwd_d      = wdata;
        state_d    = S_COMP;
        c_en_d     = 1'b1;
        c_comp_d   = 1'b1;
        c_write_d  = wr;
        c_addr_d   = addr;
        c_tag_in_d = addr[AW-1 -: TAG_W];
        c_din_d    = wdata;
      end
      S_COMP: begin
        wc_d = '0;
        if (c_hit && c_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = rw_q ? '0 : c_dout;
        end else if (c_valid && c_dirty) begin
          victim_d   = c_tag_out;
          state_d    = S_WB_RD;
          c_en_d     = 1'b1;
          c_addr_d   = {c_tag_out, r_idx, {OFF_W{1'b0}}};
          c_tag_in_d = c_tag_out;
        end else begin
          state_d  = S_FILL;
          m_req_d  = 1'b1;
          m_addr_d = {r_tag, r_idx, {OFF_W{1'b0}}};
        end
      end
      S_WB_RD: begin
        state_d   = S_WB_MEM;
        m_req_d   = 1'b1;
        m_we_d    = 1'b1;
        m_addr_d  = {victim_q, r_idx, wc_q};
        m_wdata_d = c_dout;
      end
      S_WB_MEM: if (m_ack) begin
        wc_d = wc_inc;
        if (wc_last) begin
          state_d  = S_FILL;
          m_req_d  = 1'b1;
          m_addr_d = {r_tag, r_idx, {OFF_W{1'b0}}};
        end else begin
          state_d    = S_WB_RD;
          c_en_d     = 1'b1;
          c_addr_d   = {victim_q, r_idx, wc_inc};
          c_tag_in_d = victim_q;
        end
      end else begin
        m_req_d = 1'b1;
        m_we_d  = 1'b1;
      end
      S_FILL: if (m_ack) begin
        state_d      = S_FWR;
        c_en_d       = 1'b1;
        c_write_d    = 1'b1;
        c_valid_in_d = 1'b1;
        c_addr_d     = {r_tag, r_idx, wc_q};
        c_tag_in_d   = r_tag;
        c_din_d      = m_rdata;
      end else begin
        m_req_d = 1'b1;
      end
      S_FWR: begin
        wc_d = wc_inc;
        if (wc_last) begin
          state_d    = S_COMP;
          c_en_d     = 1'b1;
          c_comp_d   = 1'b1;
          c_write_d  = rw_q;
          c_addr_d   = ra_q;
          c_tag_in_d = r_tag;
          c_din_d    = rwd_q;
        end else begin
          state_d  = S_FILL;
          m_req_d  = 1'b1;
          m_addr_d = {r_tag, r_idx, wc_inc};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;     ra_q <= '0;          rw_q <= 1'b0;       rwd_q <= '0;
      victim_q <= '0;        wc_q <= '0;          busy_q <= 1'b0;     done_q <= 1'b0;
      rdata_q <= '0;         c_en_q <= 1'b0;      c_comp_q <= 1'b0;   c_write_q <= 1'b0;
      c_valid_in_q <= 1'b0;  c_addr_q <= '0;      c_tag_in_q <= '0;   c_din_q <= '0;
      m_req_q <= 1'b0;       m_we_q <= 1'b0;      m_addr_q <= '0;     m_wdata_q <= '0;
    end else begin
      state_q <= state_d;         ra_q <= ra_d;          rw_q <= rw_d;           rwd_q <= rwd_d;
      victim_q <= victim_d;       wc_q <= wc_d;          busy_q <= busy_d;       done_q <= done_d;
      rdata_q <= rdata_d;         c_en_q <= c_en_d;      c_comp_q <= c_comp_d;   c_write_q <= c_write_d;
      c_valid_in_q <= c_valid_in_d; c_addr_q <= c_addr_d; c_tag_in_q <= c_tag_in_d; c_din_q <= c_din_d;
      m_req_q <= m_req_d;         m_we_q <= m_we_d;      m_addr_q <= m_addr_d;   m_wdata_q <= m_wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign c_en       = c_en_q;
  assign c_comp     = c_comp_q;
  assign c_write    = c_write_q;
  assign c_valid_in = c_valid_in_q;
  assign c_addr     = c_addr_q;
  assign c_tag_in   = c_tag_in_q;
  assign c_din      = c_din_q;
  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural direct-mapped cache and fixed-latency word memory,
// expected load data queued at issue and compared on done.
module tb_cache_ctrl;
  localparam int MEM_L   = 2;
  localparam int T_HIT   = 2;
  localparam int T_CLEAN = 2 + 4 * (MEM_L + 1) + 1;
  localparam int T_DIRTY = T_CLEAN + 4 * (MEM_L + 1);

  logic        clk = 1'b0;
  logic        rst_n, req, wr;
  logic [12:0] addr;
  logic [15:0] wdata, rdata, c_din, c_dout, m_wdata, m_rdata;
  logic        busy, done, c_en, c_comp, c_write, c_valid_in, c_hit, c_dirty, c_valid;
  logic [12:0] c_addr, m_addr;
  logic [4:0]  c_tag_in, c_tag_out;
  logic        m_req, m_we, m_ack;

  always #5 clk = ~clk;

  cache_ctrl #(.TAG_W(5), .IDX_W(6), .OFF_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .c_en(c_en), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_addr(c_addr), .c_tag_in(c_tag_in), .c_din(c_din),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out), .c_dout(c_dout),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  // Behavioural cache: combinational lookup, writes on the rising edge.
  logic [4:0]  ctag [64];
  logic        cval [64];
  logic        cdirty [64];
  logic [15:0] cdata [256];
  logic        pl_clr, pl_en, pl_v, pl_d;
  logic [5:0]  pl_idx;
  logic [4:0]  pl_tag;
  logic [15:0] pl_base;
  int          aw_cnt = 0;

  assign c_tag_out = ctag[c_addr[7:2]];
  assign c_valid   = cval[c_addr[7:2]];
  assign c_dirty   = cdirty[c_addr[7:2]];
  assign c_dout    = cdata[c_addr[7:0]];
  assign c_hit     = c_comp && (ctag[c_addr[7:2]] == c_tag_in);

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 64; i++) begin ctag[i] <= '0; cval[i] <= 1'b0; cdirty[i] <= 1'b0; end
      for (int i = 0; i < 256; i++) cdata[i] <= '0;
    end else if (pl_en) begin
      ctag[pl_idx] <= pl_tag; cval[pl_idx] <= pl_v; cdirty[pl_idx] <= pl_d;
      for (int k = 0; k < 4; k++) cdata[{pl_idx, 2'(k)}] <= pl_base + 16'(k);
    end else if (c_en && c_write) begin
      if (c_comp) begin
        if (c_hit && c_valid) begin cdata[c_addr[7:0]] <= c_din; cdirty[c_addr[7:2]] <= 1'b1; end
      end else begin
        cdata[c_addr[7:0]] <= c_din; ctag[c_addr[7:2]] <= c_tag_in;
        cval[c_addr[7:2]] <= c_valid_in; cdirty[c_addr[7:2]] <= 1'b0;
        aw_cnt <= aw_cnt + 1;
      end
    end
  end

  // Word memory: ack in the MEM_L-th cycle of each request, driven on the falling edge.
  logic [15:0] mem [8192];
  logic [12:0] rd_addr_q [$];
  logic [12:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          cnt = 0;
  int          mreq_cycles = 0;

  function automatic logic [15:0] pat(input logic [12:0] a);
    return 16'hA5C3 ^ {a[2:0], a};
  endfunction

  always @(negedge clk) begin
    if (pl_clr) for (int i = 0; i < 8192; i++) mem[i] <= pat(13'(i));
    if (!rst_n || !m_req) begin
      cnt <= 0; m_ack <= 1'b0;
    end else if (cnt + 1 == MEM_L) begin
      cnt <= 0; m_ack <= 1'b1;
      if (m_we) begin
        mem[m_addr] <= m_wdata; wr_addr_q.push_back(m_addr); wr_data_q.push_back(m_wdata);
      end else begin
        m_rdata <= mem[m_addr]; rd_addr_q.push_back(m_addr);
      end
    end else begin
      cnt <= cnt + 1; m_ack <= 1'b0;
    end
    if (m_req) mreq_cycles <= mreq_cycles + 1;
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_q [$];

  task automatic preload(input logic [5:0] idx, input logic [4:0] tg, input logic v,
                         input logic d, input logic [15:0] base);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_tag = tg; pl_v = v; pl_d = d; pl_base = base;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_req(input logic rw, input logic [12:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output bit ok);
    @(negedge clk);
    req = 1'b1; wr = rw; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    lat = 1; ok = 1'b0; rd = '0;
    while (!ok && lat < 300) begin
      if (done) begin ok = 1'b1; rd = rdata; end
      else begin @(posedge clk); @(negedge clk); lat++; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_total++; if ({busy, done, m_req, m_we, c_en, c_comp, c_write, c_valid_in} !== 8'h00)
      $display("FAIL reset_ctl: got %b expected 00000000", {busy, done, m_req, m_we, c_en, c_comp, c_write, c_valid_in}); else n_pass++;
    n_total++; if ({rdata, m_addr, m_wdata, c_addr, c_din, c_tag_in} !== 79'h0)
      $display("FAIL reset_data: got %h expected 0", {rdata, m_addr, m_wdata, c_addr, c_din, c_tag_in}); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_read_hit;
    int lat; logic [15:0] rd, e; bit ok; int m0;
    preload(6'd3, 5'h05, 1'b1, 1'b0, 16'h1000);
    m0 = mreq_cycles;
    exp_q.push_back(16'h1001);
    run_req(1'b0, 13'h050D, 16'h0, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok) $display("FAIL hit_done: got timeout expected done"); else n_pass++;
    n_total++; if (lat !== T_HIT) $display("FAIL hit_latency: got %0d expected %0d", lat, T_HIT); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL hit_rdata: got %h expected %h", rd, e); else n_pass++;
    n_total++; if (mreq_cycles - m0 !== 0) $display("FAIL hit_no_mreq: got %0d expected 0", mreq_cycles - m0); else n_pass++;
  endtask

  task automatic test_clean_miss;
    int lat; logic [15:0] rd, e; bit ok; int r0, w0, a0;
    r0 = rd_addr_q.size(); w0 = wr_addr_q.size(); a0 = aw_cnt;
    exp_q.push_back(pat(13'h0A10));
    run_req(1'b0, 13'h0A10, 16'h0, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || lat !== T_CLEAN) $display("FAIL clean_latency: got %0d expected %0d", lat, T_CLEAN); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL clean_rdata: got %h expected %h", rd, e); else n_pass++;
    n_total++; if (rd_addr_q.size() - r0 !== 4) $display("FAIL clean_reads: got %0d expected 4", rd_addr_q.size() - r0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (rd_addr_q[r0 + k] !== 13'h0A10 + 13'(k))
        $display("FAIL clean_read_addr%0d: got %h expected %h", k, rd_addr_q[r0 + k], 13'h0A10 + 13'(k)); else n_pass++;
    end
    n_total++; if (wr_addr_q.size() - w0 !== 0) $display("FAIL clean_no_wb: got %0d expected 0", wr_addr_q.size() - w0); else n_pass++;
    n_total++; if (aw_cnt - a0 !== 4) $display("FAIL clean_fill_writes: got %0d expected 4", aw_cnt - a0); else n_pass++;
  endtask

  task automatic test_dirty_miss;
    int lat; logic [15:0] rd, e; bit ok; int r0, w0;
    preload(6'd4, 5'h02, 1'b1, 1'b1, 16'h2000);
    r0 = rd_addr_q.size(); w0 = wr_addr_q.size();
    exp_q.push_back(pat(13'h1F12));
    run_req(1'b0, 13'h1F12, 16'h0, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || lat !== T_DIRTY) $display("FAIL dirty_latency: got %0d expected %0d", lat, T_DIRTY); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL dirty_rdata: got %h expected %h", rd, e); else n_pass++;
    n_total++; if (wr_addr_q.size() - w0 !== 4) $display("FAIL dirty_wb_count: got %0d expected 4", wr_addr_q.size() - w0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if ({wr_addr_q[w0 + k], wr_data_q[w0 + k]} !== {13'h0210 + 13'(k), 16'h2000 + 16'(k)})
        $display("FAIL dirty_wb%0d: got %h/%h expected %h/%h", k, wr_addr_q[w0 + k], wr_data_q[w0 + k],
                 13'h0210 + 13'(k), 16'h2000 + 16'(k)); else n_pass++;
      n_total++; if (rd_addr_q[r0 + k] !== 13'h1F10 + 13'(k))
        $display("FAIL dirty_fill%0d: got %h expected %h", k, rd_addr_q[r0 + k], 13'h1F10 + 13'(k)); else n_pass++;
    end
  endtask

  task automatic test_store_load;
    int lat; logic [15:0] rd, e; bit ok;
    exp_q.push_back(16'h0000);
    run_req(1'b1, 13'h0345, 16'hBEEF, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || lat !== T_CLEAN) $display("FAIL store_latency: got %0d expected %0d", lat, T_CLEAN); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL store_rdata: got %h expected %h", rd, e); else n_pass++;
    exp_q.push_back(16'hBEEF);
    run_req(1'b0, 13'h0345, 16'h0, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || lat !== T_HIT) $display("FAIL load_after_store_latency: got %0d expected %0d", lat, T_HIT); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL load_after_store_rdata: got %h expected %h", rd, e); else n_pass++;
    n_total++; if (cdirty[17] !== 1'b1) $display("FAIL store_line_dirty: got %b expected 1", cdirty[17]); else n_pass++;
  endtask

  task automatic test_invalid_dirty;
    int lat; logic [15:0] rd, e; bit ok; int w0;
    preload(6'd20, 5'h07, 1'b0, 1'b1, 16'h3000);
    w0 = wr_addr_q.size();
    exp_q.push_back(pat(13'h0752));
    run_req(1'b0, 13'h0752, 16'h0, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || lat !== T_CLEAN) $display("FAIL invdirty_latency: got %0d expected %0d", lat, T_CLEAN); else n_pass++;
    n_total++; if (wr_addr_q.size() - w0 !== 0) $display("FAIL invdirty_no_wb: got %0d expected 0", wr_addr_q.size() - w0); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL invdirty_rdata: got %h expected %h", rd, e); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int d1, d2; logic [15:0] r1, r2, e; logic busy3;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0; busy3 = 1'b1;
    exp_q.push_back(16'h1001); exp_q.push_back(16'h1002);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 13'h050D;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) busy3 = busy;
      if (done && d1 == 0) begin d1 = c; r1 = rdata; addr = 13'h050E; end
      else if (done && d2 == 0) begin d2 = c; r2 = rdata; req = 1'b0; end
      @(posedge clk);
    end
    req = 1'b0; addr = '0;
    e = exp_q.pop_front();
    n_total++; if (d1 !== 2 || r1 !== e) $display("FAIL b2b_first: got cyc %0d data %h expected cyc 2 data %h", d1, r1, e); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if (d2 !== 5 || r2 !== e) $display("FAIL b2b_second: got cyc %0d data %h expected cyc 5 data %h", d2, r2, e); else n_pass++;
    n_total++; if (busy3 !== 1'b0) $display("FAIL b2b_idle_gap: got busy %b expected 0", busy3); else n_pass++;
  endtask

  task automatic test_reset_mid_fill;
    int lat; logic [15:0] rd, e; bit ok, got, dseen; int r0, c;
    r0 = rd_addr_q.size(); got = 1'b0; dseen = 1'b0; c = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 13'h1178;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; addr = '0;
    while (!got && c < 100) begin
      @(negedge clk); #1;
      if (done) dseen = 1'b1;
      if (rd_addr_q.size() >= r0 + 2) got = 1'b1; else c++;
    end
    n_total++; if (!got) $display("FAIL rst_two_acks: got timeout expected two fill acks"); else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    n_total++; if ({busy, done, m_req, m_we, c_en, c_comp, c_write, c_valid_in} !== 8'h00)
      $display("FAIL rst_mid_ctl: got %b expected 00000000", {busy, done, m_req, m_we, c_en, c_comp, c_write, c_valid_in}); else n_pass++;
    n_total++; if ({rdata, m_addr, m_wdata, c_addr, c_din, c_tag_in} !== 79'h0)
      $display("FAIL rst_mid_data: got %h expected 0", {rdata, m_addr, m_wdata, c_addr, c_din, c_tag_in}); else n_pass++;
    n_total++; if (dseen !== 1'b0) $display("FAIL rst_no_done: got %b expected 0", dseen); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h1001);
    run_req(1'b0, 13'h050D, 16'h0, lat, rd, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || lat !== T_HIT) $display("FAIL post_rst_latency: got %0d expected %0d", lat, T_HIT); else n_pass++;
    n_total++; if (rd !== e) $display("FAIL post_rst_rdata: got %h expected %h", rd, e); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    pl_clr = 1'b1; pl_en = 1'b0; pl_v = 1'b0; pl_d = 1'b0; pl_idx = '0; pl_tag = '0; pl_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pl_clr = 1'b0;
    test_reset;
    test_read_hit;
    test_clean_miss;
    test_dirty_miss;
    test_store_load;
    test_invalid_dirty;
    test_back_to_back;
    test_reset_mid_fill;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
